rem_diff_seq: RTL and testbench

Sequential replacement for the combinational remainder-of-difference path. The block computes DIFF = X − Y (unsigned, modulo 2^16), then X mod DIFF and X div DIFF, using a 16-iteration restoring shift-subtract divider. It replaces the unbounded combinational subtract loop with fixed latency and a start/busy/done handshake. Each result is written into an 8-entry result store, which downstream logic reads through a combinational read port.

---
 rtl/rem_diff_pkg.sv | 16 +
 rtl/rem_store.sv | 35 +++
 rtl/rem_diff_seq.sv | 167 ++++++++++++++++
 tb/tb_rem_diff_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rem_diff_pkg.sv
// Shared types and constants for the sequential remainder-of-difference block.
package rem_diff_pkg;

    localparam int WIDTH_DEF = 16;

    // Wide enough to count 0..WIDTH_DEF divider iterations.
    localparam int CNT_W = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rem_store.sv
// Small result register file with synchronous write, combinational read
// and synchronous clear to zero.
module rem_store
    import rem_diff_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A same-cycle write to raddr becomes visible only after the edge.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rem_diff_seq.sv
// Computes X mod (X-Y) and X div (X-Y) with a restoring shift-subtract divider
// and records each remainder into a small result store.
module rem_diff_seq
    import rem_diff_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [DEPTH_W-1:0] wr_addr,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   rem_out,
    output logic [WIDTH-1:0]   quot_out,
    output logic               dz,
    input  logic [DEPTH_W-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [DEPTH_W-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   diff;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     iter_p;
    logic [WIDTH-1:0]   iter_q;
    logic               store_we;

    assign diff  = x_q - y_q;
    assign trial = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

    always_comb begin
        iter_p = trial;
        iter_q = {q_q[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, d_q}) begin
            iter_p = trial - {1'b0, d_q};
            iter_q = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        waddr_d  = waddr_q;
        d_d      = d_q;
        p_d      = p_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dz_d     = dz_q;
        store_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    waddr_d = wr_addr;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                d_d   = diff;
                p_d   = '0;
                q_d   = x_q;
                cnt_d = '0;
                if (diff == '0) begin
                    rem_d   = x_q;
                    quot_d  = '0;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                p_d   = iter_p;
                q_d   = iter_q;
                cnt_d = cnt_q + 1'b1;
                // Results are loaded on the final iteration so they are valid throughout DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    rem_d   = iter_p[WIDTH-1:0];
                    quot_d  = iter_q;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                store_we = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            waddr_q <= '0;
            d_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            waddr_q <= waddr_d;
            d_q     <= d_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    rem_store #(
        .WIDTH  (WIDTH),
        .DEPTH_W(DEPTH_W)
    ) u_store (
        .clk  (clk),
        .rst  (rst),
        .we   (store_we),
        .waddr(waddr_q),
        .wdata(rem_q),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rem_out  = rem_q;
    assign quot_out = quot_q;
    assign dz       = dz_q;

endmodule

// File: tb/tb_rem_diff_seq.sv
// Self-checking bench for rem_diff_seq: directed vector table, randomized
// operands against a plain-arithmetic model, and start-ignore / reset sequences.
module tb_rem_diff_seq;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  x, y;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          busy, done, dz;
    logic [W-1:0]  rem_out, quot_out, rd_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] storeModel [8];

    typedef struct {
        logic [W-1:0]  xv;
        logic [W-1:0]  yv;
        logic [AW-1:0] addr;
        logic [W-1:0]  eRem;
        logic [W-1:0]  eQuot;
        logic          eDz;
        int            eLat;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    rem_diff_seq #(.WIDTH(W), .DEPTH_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .wr_addr (wr_addr),
        .busy    (busy),
        .done    (done),
        .rem_out (rem_out),
        .quot_out(quot_out),
        .dz      (dz),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural reference: plain modular arithmetic on the wrapped difference.
    task automatic modelResult(input logic [W-1:0] xv, input logic [W-1:0] yv,
                               output logic [W-1:0] r, output logic [W-1:0] q,
                               output logic z, output int lat);
        logic [W-1:0] dv;
        dv = xv - yv;
        if (dv == 0) begin
            r = xv; q = 0; z = 1'b1; lat = 2;
        end else begin
            r = xv % dv; q = xv / dv; z = 1'b0; lat = 18;
        end
    endtask

    task automatic checkStore();
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            #1;
            checkOutput($sformatf("store[%0d]", a), rd_data, storeModel[a]);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input logic [AW-1:0] ai, input logic [W-1:0] eRem,
                                 input logic [W-1:0] eQuot, input logic eDz, input int eLat);
        int lat;
        @(negedge clk);
        x = xi; y = yi; wr_addr = ai; rd_addr = ai; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = $urandom; y = $urandom; wr_addr = AW'($urandom);
        checkOutput("busy_after_accept", busy, 1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=no_done expected=done_by_cycle_%0d", eLat);
            return;
        end
        checkOutput("latency", lat, eLat);
        checkOutput("rem_out", rem_out, eRem);
        checkOutput("quot_out", quot_out, eQuot);
        checkOutput("dz", dz, eDz);
        checkOutput("busy_in_done", busy, 1);
        checkOutput("rd_old_in_done", rd_data, storeModel[ai]);
        storeModel[ai] = eRem;
        @(negedge clk);
        checkOutput("done_single_pulse", done, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("rd_after_write", rd_data, eRem);
        checkOutput("rem_held", rem_out, eRem);
    endtask

    initial begin
        logic [W-1:0]  rx, ry, mr, mq;
        logic [AW-1:0] ra;
        logic          mz;
        int            ml, doneCount;

        vecs[0] = '{16'd100,   16'd30,    3'd2, 16'd30, 16'd1,     1'b0, 18};
        vecs[1] = '{16'd1000,  16'd993,   3'd5, 16'd6,  16'd142,   1'b0, 18};
        vecs[2] = '{16'd55,    16'd55,    3'd1, 16'd55, 16'd0,     1'b1, 2};
        vecs[3] = '{16'd5,     16'd10,    3'd7, 16'd5,  16'd0,     1'b0, 18};
        vecs[4] = '{16'd0,     16'd1,     3'd0, 16'd0,  16'd0,     1'b0, 18};
        vecs[5] = '{16'd65535, 16'd0,     3'd3, 16'd0,  16'd1,     1'b0, 18};
        vecs[6] = '{16'd65535, 16'd65534, 3'd4, 16'd0,  16'd65535, 1'b0, 18};

        for (int a = 0; a < 8; a++) storeModel[a] = '0;

        rst = 1'b1; start = 1'b0; x = '0; y = '0; wr_addr = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rem", rem_out, 0);
        checkOutput("reset_quot", quot_out, 0);
        checkOutput("reset_dz", dz, 0);
        rst = 1'b0;
        checkStore();

        $display("[TB] directed vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].xv, vecs[i].yv, vecs[i].addr,
                          vecs[i].eRem, vecs[i].eQuot, vecs[i].eDz, vecs[i].eLat);
        end
        checkStore();

        $display("[TB] randomized operands");
        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom);
            case ($urandom_range(3))
                0: ry = rx;
                1: ry = rx - W'($urandom_range(1, 20));
                default: ry = W'($urandom);
            endcase
            ra = AW'($urandom);
            modelResult(rx, ry, mr, mq, mz, ml);
            applyStimulus(rx, ry, ra, mr, mq, mz, ml);
        end
        checkStore();

        $display("[TB] start during division is ignored");
        @(negedge clk);
        x = 16'd100; y = 16'd30; wr_addr = 3'd6; rd_addr = 3'd6; start = 1'b1;
        doneCount = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 8);
            if (k == 8) begin x = 16'd7; y = 16'd3; wr_addr = 3'd0; end
            if (done) begin
                doneCount++;
                checkOutput("ignore_latency", k, 18);
                checkOutput("ignore_rem", rem_out, 30);
                checkOutput("ignore_quot", quot_out, 1);
            end
        end
        checkOutput("ignore_done_count", doneCount, 1);
        storeModel[6] = 16'd30;
        checkStore();

        $display("[TB] reset mid-division");
        @(negedge clk);
        x = 16'd100; y = 16'd30; wr_addr = 3'd2; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_rem", rem_out, 0);
        checkOutput("midrst_quot", quot_out, 0);
        checkOutput("midrst_dz", dz, 0);
        for (int a = 0; a < 8; a++) storeModel[a] = '0;
        doneCount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) doneCount++;
        end
        checkOutput("midrst_no_activity", doneCount, 0);
        checkStore();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
